axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_reg_slave.sv | 181 ++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable read/write registers.
// Latency: bvalid one cycle after the edge where both AW and W are in; rvalid one cycle after AR.
// Backpressure: one write and one read outstanding; readies drop while a response waits.
//
// Ports:
//   s0_axi_aclk / s0_axi_aresetn : clock (rising edge), async active-low reset
//   s0_axi_aw* / s0_axi_w*       : write address and data channels (accepted independently)
//   s0_axi_b*                    : write response, bresp 1 = out-of-range index
//   s0_axi_ar* / s0_axi_r*       : read address and data, rresp 1 = out-of-range index
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REGS   = 8
) (
   input  logic                    s0_axi_aclk,
   input  logic                    s0_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic                    s0_axi_awvalid,
   output logic                    s0_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
   input  logic                    s0_axi_wvalid,
   output logic                    s0_axi_wready,
   output logic                    s0_axi_bresp,
   output logic                    s0_axi_bvalid,
   input  logic                    s0_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
   input  logic                    s0_axi_arvalid,
   output logic                    s0_axi_arready,
   output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
   output logic                    s0_axi_rresp,
   output logic                    s0_axi_rvalid,
   input  logic                    s0_axi_rready
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = ADDR_WIDTH - 2;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t              w_state;
   r_state_t              r_state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Holds all readies low during reset and releases them on the first edge after it.
   logic                  live;

   logic                  aw_held;
   logic                  w_held;
   logic [IW-1:0]         aw_idx_q;
   logic [DATA_WIDTH-1:0] w_dat_q;
   logic [NB-1:0]         w_strb_q;

   logic                  bvalid_q;
   logic                  bresp_q;
   logic                  rvalid_q;
   logic                  rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic [IW-1:0]         wr_idx;
   logic [DATA_WIDTH-1:0] wr_dat;
   logic [NB-1:0]         wr_strb;
   logic                  wr_oor;
   logic                  wr_commit;
   logic [IW-1:0]         ar_idx;
   logic                  ar_oor;
   logic [DATA_WIDTH-1:0] rd_val;

   // Byte-offset bits inside a word carry no information for this register map.
   logic                  unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

   assign s0_axi_awready = live & ~aw_held & ~bvalid_q;
   assign s0_axi_wready  = live & ~w_held & ~bvalid_q;
   assign s0_axi_arready = live & (r_state == R_IDLE);
   assign s0_axi_bvalid  = bvalid_q;
   assign s0_axi_bresp   = bresp_q;
   assign s0_axi_rvalid  = rvalid_q;
   assign s0_axi_rresp   = rresp_q;
   assign s0_axi_rdata   = rdata_q;

   assign aw_hs = s0_axi_awvalid & s0_axi_awready;
   assign w_hs  = s0_axi_wvalid & s0_axi_wready;
   assign ar_hs = s0_axi_arvalid & s0_axi_arready;

   // A channel counts as available if it was held earlier or is handshaking on this edge.
   assign wr_idx    = aw_held ? aw_idx_q : s0_axi_awaddr[ADDR_WIDTH-1:2];
   assign wr_dat    = w_held ? w_dat_q : s0_axi_wdata;
   assign wr_strb   = w_held ? w_strb_q : s0_axi_wstrb;
   assign wr_oor    = int'(wr_idx) >= NUM_REGS;
   assign wr_commit = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

   assign ar_idx = s0_axi_araddr[ADDR_WIDTH-1:2];
   assign ar_oor = int'(ar_idx) >= NUM_REGS;

   always_comb begin
      rd_val = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (int'(ar_idx) == r) rd_val = regs[r];
      end
   end

   // Register file: byte-lane merge on commit; a read on the same edge sees the old value.
   always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
      if (!s0_axi_aresetn) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wr_commit && !wr_oor) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(wr_idx) == r) begin
               for (int b = 0; b < NB; b++) begin
                  if (wr_strb[b]) regs[r][8*b +: 8] <= wr_dat[8*b +: 8];
               end
            end
         end
      end
   end

   // Write FSM: collect AW and W in any order, then hold the response until bready.
   always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
      if (!s0_axi_aresetn) begin
         live     <= 1'b0;
         w_state  <= W_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         w_dat_q  <= '0;
         w_strb_q <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= 1'b0;
      end else begin
         live <= 1'b1;
         if (w_state == W_IDLE) begin
            if (wr_commit) begin
               w_state  <= W_RESP;
               bvalid_q <= 1'b1;
               bresp_q  <= wr_oor;
               aw_held  <= 1'b0;
               w_held   <= 1'b0;
            end else begin
               if (aw_hs) begin
                  aw_held  <= 1'b1;
                  aw_idx_q <= s0_axi_awaddr[ADDR_WIDTH-1:2];
               end
               if (w_hs) begin
                  w_held   <= 1'b1;
                  w_dat_q  <= s0_axi_wdata;
                  w_strb_q <= s0_axi_wstrb;
               end
            end
         end else if (s0_axi_bready) begin
            w_state  <= W_IDLE;
            bvalid_q <= 1'b0;
         end
      end
   end

   // Read FSM: data captured on the AR edge and held until rready.
   always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
      if (!s0_axi_aresetn) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= 1'b0;
         rdata_q  <= '0;
      end else if (r_state == R_IDLE) begin
         if (ar_hs) begin
            r_state  <= R_DATA;
            rvalid_q <= 1'b1;
            rresp_q  <= ar_oor;
            rdata_q  <= ar_oor ? '0 : rd_val;
         end
      end else if (s0_axi_rready) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
`timescale 1ns/1ps
module tb_axil_reg_slave;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bresp, bvalid, bready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic          arvalid, arready, rresp, rvalid, rready;

   always #5 clk = ~clk;

   axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
      .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
      .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
      .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
      .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
      .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] model [NR];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: word array indexed by byte address / 4, byte-lane merge.
   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [3:0] s, output logic resp);
      int idx = int'(a) / 4;
      if (idx < NR) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
         resp = 1'b0;
      end else begin
         resp = 1'b1;
      end
   endtask

   task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic resp);
      int idx = int'(a) / 4;
      if (idx < NR) begin d = model[idx]; resp = 1'b0; end
      else          begin d = '0;         resp = 1'b1; end
   endtask

   // Drive AW after ad cycles and W after wd cycles; returns once both are accepted.
   task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int ad, input int wd);
      bit aw_done = 0, w_done = 0, aw_go, w_go;
      int c = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done)) begin
         if (c > 60) begin
            check("wr_accept_timeout", 1, 0);
            awvalid = 0; wvalid = 0;
            return;
         end
         awvalid = !aw_done && (c >= ad);
         wvalid  = !w_done && (c >= wd);
         aw_go   = awvalid && awready;
         w_go    = wvalid && wready;
         @(negedge clk);
         if (aw_go) aw_done = 1;
         if (w_go)  w_done = 1;
         c++;
      end
      awvalid = 0; wvalid = 0;
   endtask

   task automatic wait_b(output logic resp);
      int t = 0;
      bready = 1;
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      if (!bvalid) begin
         check("bvalid_timeout", 0, 1);
         resp = 1'bx;
         return;
      end
      resp = bresp;
      @(negedge clk);
      check("bvalid_drop", bvalid, 0);
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic resp);
      int t = 0;
      araddr = a; arvalid = 1; rready = 1;
      while (!arready && t < 20) begin @(negedge clk); t++; end
      if (!arready) begin
         check("arready_timeout", 0, 1);
         arvalid = 0; d = 'x; resp = 1'bx;
         return;
      end
      @(negedge clk);
      arvalid = 0;
      check("rvalid_latency", rvalid, 1);
      d = rdata; resp = rresp;
      @(negedge clk);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    strb;
      logic          exp_resp;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic          r, er;
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a;
      logic [3:0]    s;

      vecs[0] = '{8'h00, 32'h0000_0017, 4'hF, 1'b0, 32'h0000_0017};
      vecs[1] = '{8'h04, 32'h1122_3344, 4'hF, 1'b0, 32'h1122_3344};
      vecs[2] = '{8'h04, 32'hAABB_CCDD, 4'h1, 1'b0, 32'h1122_33DD};
      vecs[3] = '{8'h08, 32'hCAFE_F00D, 4'h6, 1'b0, 32'h00FE_F000};
      vecs[4] = '{8'h40, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0000_0000};
      vecs[5] = '{8'h1F, 32'h1234_5678, 4'hF, 1'b0, 32'h1234_5678};
      vecs[6] = '{8'h20, 32'h0BAD_F00D, 4'hF, 1'b1, 32'h0000_0000};

      for (int i = 0; i < NR; i++) model[i] = '0;
      rst_n = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      rst_n = 1;
      @(negedge clk);
      check("post_rst_awready", awready, 1);
      check("post_rst_wready", wready, 1);
      check("post_rst_arready", arready, 1);

      // Table: write, check response, read back
      for (int i = 0; i < 7; i++) begin
         send_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
         check("tbl_bvalid_latency", bvalid, 1);
         wait_b(r);
         check("tbl_bresp", r, vecs[i].exp_resp);
         model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, er);
         do_read(vecs[i].addr, d, r);
         check("tbl_rdata", d, vecs[i].exp_rd);
         check("tbl_rresp", r, vecs[i].exp_resp);
      end
      for (int i = 0; i < NR; i++) begin
         do_read(8'(i * 4), d, r);
         check("tbl_all_regs", d, model[i]);
      end

      // W arrives three cycles ahead of AW
      wdata = 32'h1E; wstrb = 4'hF; wvalid = 1;
      check("wfirst_wready", wready, 1);
      @(negedge clk);
      wvalid = 0;
      for (int k = 0; k < 3; k++) begin
         check("wfirst_wready_low", wready, 0);
         check("wfirst_no_bvalid", bvalid, 0);
         check("wfirst_awready", awready, 1);
         @(negedge clk);
      end
      awaddr = 8'h10; awvalid = 1;
      @(negedge clk);
      awvalid = 0;
      check("wfirst_bvalid", bvalid, 1);
      wait_b(r);
      check("wfirst_bresp", r, 0);
      model_write(8'h10, 32'h1E, 4'hF, er);
      do_read(8'h10, d, r);
      check("wfirst_rdata", d, 32'h1E);

      // bready stall
      bready = 0;
      send_wr(8'h0C, 32'hA5A5_0F0F, 4'hF, 0, 0);
      for (int k = 0; k < 4; k++) begin
         check("bstall_bvalid", bvalid, 1);
         check("bstall_bresp", bresp, 0);
         check("bstall_awready", awready, 0);
         check("bstall_wready", wready, 0);
         @(negedge clk);
      end
      bready = 1;
      @(negedge clk);
      check("bstall_release", bvalid, 0);
      model_write(8'h0C, 32'hA5A5_0F0F, 4'hF, er);

      // rready stall
      rready = 0; araddr = 8'h0C; arvalid = 1;
      @(negedge clk);
      arvalid = 0;
      for (int k = 0; k < 4; k++) begin
         check("rstall_rvalid", rvalid, 1);
         check("rstall_rdata", rdata, model[3]);
         check("rstall_arready", arready, 0);
         @(negedge clk);
      end
      rready = 1;
      @(negedge clk);
      check("rstall_release", rvalid, 0);

      // Read and write of reg 0 on the same edge: read sees old value
      ed = model[0];
      awaddr = 8'h00; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 8'h00;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("same_edge_rdata", rdata, ed);
      check("same_edge_bvalid", bvalid, 1);
      check("same_edge_bresp", bresp, 0);
      model_write(8'h00, 32'h5555_AAAA, 4'hF, er);
      @(negedge clk);
      do_read(8'h00, d, r);
      check("same_edge_newval", d, 32'h5555_AAAA);

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         a = 8'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         send_wr(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
         wait_b(r);
         model_write(a, d, s, er);
         check("rand_bresp", r, er);
         a = 8'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
         do_read(a, d, r);
         model_read(a, ed, er);
         check("rand_rdata", d, ed);
         check("rand_rresp", r, er);
      end

      // Reset with a write response and read data both pending
      bready = 0; rready = 0;
      send_wr(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0);
      araddr = 8'h04; arvalid = 1;
      @(negedge clk);
      arvalid = 0;
      check("pre_rst_bvalid", bvalid, 1);
      check("pre_rst_rvalid", rvalid, 1);
      #2 rst_n = 0;
      #1;
      check("async_rst_bvalid", bvalid, 0);
      check("async_rst_rvalid", rvalid, 0);
      check("async_rst_rdata", rdata, 0);
      check("async_rst_awready", awready, 0);
      check("async_rst_arready", arready, 0);
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(negedge clk);
      rst_n = 1;
      check("rst_release_no_edge", awready, 0);
      @(negedge clk);
      check("rst_release_awready", awready, 1);
      check("rst_release_wready", wready, 1);
      check("rst_release_arready", arready, 1);
      bready = 1; rready = 1;
      do_read(8'h00, d, r);
      check("post_rst_reg0", d, 0);
      do_read(8'h04, d, r);
      check("post_rst_reg1", d, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
